// File: rtl/ddc_decim_core.sv
// rtl/ddc_decim_core.sv - multi-lane I/Q mixer with integrate-and-dump decimator and 2-entry result FIFO
`timescale 1ns/1ps
module ddc_decim_core #(
  parameter int LANES    = 4,
  parameter int ADC_W    = 12,
  parameter int COEF_W   = 16,
  parameter int DEC_BITS = 8,
  localparam int OUT_W   = ADC_W + COEF_W + $clog2(LANES) + DEC_BITS
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        valid_i,
  input  logic [LANES*ADC_W-1:0]      sample_i,
  input  logic [LANES*COEF_W-1:0]     cos_i,
  input  logic [LANES*COEF_W-1:0]     sin_i,
  input  logic [DEC_BITS-1:0]         dec_ratio_i,
  input  logic                        clear_i,
  input  logic                        out_ready_i,
  output logic                        out_valid_o,
  output logic signed [OUT_W-1:0]     inphase_o,
  output logic signed [OUT_W-1:0]     quadrature_o,
  output logic                        overrun_o
);

  localparam int PROD_W = ADC_W + COEF_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  typedef enum logic {IDLE, ACC} state_t;

  logic                      s1_valid_q, s1_valid_d;
  logic signed [PROD_W-1:0]  s1_prod_re_q [LANES];
  logic signed [PROD_W-1:0]  s1_prod_re_d [LANES];
  logic signed [PROD_W-1:0]  s1_prod_im_q [LANES];
  logic signed [PROD_W-1:0]  s1_prod_im_d [LANES];
  logic                      s2_valid_q, s2_valid_d;
  logic signed [SUM_W-1:0]   s2_sum_re_q, s2_sum_re_d;
  logic signed [SUM_W-1:0]   s2_sum_im_q, s2_sum_im_d;

  state_t                    state_q, state_d;
  logic [DEC_BITS-1:0]       ratio_q, ratio_d;
  logic [DEC_BITS-1:0]       count_q, count_d;
  logic signed [OUT_W-1:0]   acc_re_q, acc_re_d;
  logic signed [OUT_W-1:0]   acc_im_q, acc_im_d;

  logic signed [OUT_W-1:0]   fifo_re_q [2];
  logic signed [OUT_W-1:0]   fifo_re_d [2];
  logic signed [OUT_W-1:0]   fifo_im_q [2];
  logic signed [OUT_W-1:0]   fifo_im_d [2];
  logic                      rd_ptr_q, rd_ptr_d;
  logic                      wr_ptr_q, wr_ptr_d;
  logic [1:0]                fill_q, fill_d;
  logic                      overrun_q, overrun_d;

  logic [DEC_BITS-1:0]       r_eff;
  logic [DEC_BITS:0]         cnt_inc;
  logic signed [OUT_W-1:0]   next_re, next_im;
  logic                      push, pop, full, wr_en, drop;

  // Stage 1 products and stage 2 lane sums; registers hold when not qualified
  always_comb begin
    s1_valid_d  = valid_i;
    s2_valid_d  = s1_valid_q;
    s2_sum_re_d = s2_sum_re_q;
    s2_sum_im_d = s2_sum_im_q;
    for (int k = 0; k < LANES; k++) begin
      s1_prod_re_d[k] = s1_prod_re_q[k];
      s1_prod_im_d[k] = s1_prod_im_q[k];
      if (valid_i) begin
        s1_prod_re_d[k] = PROD_W'($signed(sample_i[k*ADC_W +: ADC_W])) *
                          PROD_W'($signed(cos_i[k*COEF_W +: COEF_W]));
        s1_prod_im_d[k] = PROD_W'($signed(sample_i[k*ADC_W +: ADC_W])) *
                          PROD_W'($signed(sin_i[k*COEF_W +: COEF_W]));
      end
    end
    if (s1_valid_q) begin
      s2_sum_re_d = '0;
      s2_sum_im_d = '0;
      for (int k = 0; k < LANES; k++) begin
        s2_sum_re_d = s2_sum_re_d + SUM_W'(s1_prod_re_q[k]);
        s2_sum_im_d = s2_sum_im_d + SUM_W'(s1_prod_im_q[k]);
      end
    end
  end

  // Decimation FSM: window start latches R, completion pushes the running sum
  always_comb begin
    state_d  = state_q;
    ratio_d  = ratio_q;
    count_d  = count_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    push     = 1'b0;
    r_eff    = (dec_ratio_i == '0) ? DEC_BITS'(1) : dec_ratio_i;
    cnt_inc  = {1'b0, count_q} + (DEC_BITS+1)'(1);
    next_re  = ((state_q == ACC) ? acc_re_q : '0) + OUT_W'(s2_sum_re_q);
    next_im  = ((state_q == ACC) ? acc_im_q : '0) + OUT_W'(s2_sum_im_q);
    if (!en_i) begin
      state_d = IDLE;
    end else if (s2_valid_q) begin
      case (state_q)
        IDLE: begin
          ratio_d  = r_eff;
          count_d  = DEC_BITS'(1);
          acc_re_d = next_re;
          acc_im_d = next_im;
          if (r_eff == DEC_BITS'(1)) push = 1'b1;
          else state_d = ACC;
        end
        ACC: begin
          acc_re_d = next_re;
          acc_im_d = next_im;
          count_d  = cnt_inc[DEC_BITS-1:0];
          if (cnt_inc == {1'b0, ratio_q}) begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Two-entry result FIFO; a pop frees the slot a simultaneous push needs
  always_comb begin
    pop       = (fill_q != 2'd0) && out_ready_i;
    full      = (fill_q == 2'd2);
    wr_en     = push && (!full || pop);
    drop      = push && full && !pop;
    rd_ptr_d  = pop ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d  = wr_en ? ~wr_ptr_q : wr_ptr_q;
    fill_d    = fill_q;
    if (wr_en && !pop) fill_d = fill_q + 2'd1;
    else if (!wr_en && pop) fill_d = fill_q - 2'd1;
    for (int i = 0; i < 2; i++) begin
      fifo_re_d[i] = fifo_re_q[i];
      fifo_im_d[i] = fifo_im_q[i];
    end
    if (wr_en) begin
      fifo_re_d[wr_ptr_q] = next_re;
      fifo_im_d[wr_ptr_q] = next_im;
    end
    overrun_d = (overrun_q && !clear_i) || drop;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_sum_re_q <= '0;
      s2_sum_im_q <= '0;
      for (int k = 0; k < LANES; k++) begin
        s1_prod_re_q[k] <= '0;
        s1_prod_im_q[k] <= '0;
      end
      state_q   <= IDLE;
      ratio_q   <= '0;
      count_q   <= '0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_re_q[i] <= '0;
        fifo_im_q[i] <= '0;
      end
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      fill_q    <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s2_sum_re_q <= s2_sum_re_d;
      s2_sum_im_q <= s2_sum_im_d;
      for (int k = 0; k < LANES; k++) begin
        s1_prod_re_q[k] <= s1_prod_re_d[k];
        s1_prod_im_q[k] <= s1_prod_im_d[k];
      end
      state_q   <= state_d;
      ratio_q   <= ratio_d;
      count_q   <= count_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
      for (int i = 0; i < 2; i++) begin
        fifo_re_q[i] <= fifo_re_d[i];
        fifo_im_q[i] <= fifo_im_d[i];
      end
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid_o  = (fill_q != 2'd0);
  assign inphase_o    = fifo_re_q[rd_ptr_q];
  assign quadrature_o = fifo_im_q[rd_ptr_q];
  assign overrun_o    = overrun_q;

endmodule
